// File: rtl/dlx_branch_unit.sv
// DLX branch resolution unit: tests a register against zero, decides the branch
// and produces the next fetch address through a four-state handshake (IDLE/EVAL/ADDR/DONE).
module dlx_branch_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] imm,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             a_zero,
  output logic             taken,
  output logic [WIDTH-1:0] next_pc
);

  typedef enum logic [1:0] {IDLE, EVAL, ADDR, DONE} state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BEQZ = 2'b01;
  localparam logic [1:0] OP_BNEZ = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;

  state_t           state, state_next;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, pc_q, imm_q;
  logic             eval_zero, eval_taken;
  logic [WIDTH-1:0] addr_offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EVAL;
      EVAL:    state_next = ADDR;
      ADDR:    state_next = DONE;
      DONE:    if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured only on an accepted request, so start pulses while busy cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_NONE;
      a_q   <= '0;
      pc_q  <= '0;
      imm_q <= '0;
    end else if (state == IDLE && start) begin
      op_q  <= op;
      a_q   <= A;
      pc_q  <= pc_in;
      imm_q <= imm;
    end
  end

  always_comb begin
    eval_zero  = ~|a_q;
    eval_taken = 1'b0;
    case (op_q)
      OP_BEQZ: eval_taken = eval_zero;
      OP_BNEZ: eval_taken = ~eval_zero;
      OP_JUMP: eval_taken = 1'b1;
      default: eval_taken = 1'b0;
    endcase
    addr_offset = taken ? imm_q : '0;
  end

  // Result registers hold their values through DONE and IDLE until the next request rewrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_zero  <= 1'b0;
      taken   <= 1'b0;
      next_pc <= '0;
    end else if (state == EVAL) begin
      a_zero <= eval_zero;
      taken  <= eval_taken;
    end else if (state == ADDR) begin
      next_pc <= pc_q + WIDTH'(1) + addr_offset;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_dlx_branch_unit.sv
// Directed self-checking bench for dlx_branch_unit: branch decisions, address wrap,
// DONE hold under ack=0, and asynchronous reset in the middle of a request.
module tb_dlx_branch_unit;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BEQZ = 2'b01;
  localparam logic [1:0] OP_BNEZ = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n, start, ack;
  logic [1:0]  op;
  logic [31:0] A, pc_in, imm;
  logic        busy, done, a_zero, taken;
  logic [31:0] next_pc;

  int checks = 0;
  int errors = 0;

  dlx_branch_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .pc_in(pc_in),
    .imm(imm), .ack(ack), .busy(busy), .done(done), .a_zero(a_zero),
    .taken(taken), .next_pc(next_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] pc, input logic [31:0] im);
    op = o; A = a; pc_in = pc; imm = im; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Issues one request and walks it through EVAL and ADDR into DONE, checking each step.
  task automatic runBranch(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] pc, input logic [31:0] im,
                           input logic ez, input logic et, input logic [31:0] epc);
    applyStimulus(o, a, pc, im);
    checkOutput({tag, "_eval_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_eval_done"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_addr_done"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_done"},    32'(done),   32'd1);
    checkOutput({tag, "_a_zero"},  32'(a_zero), 32'(ez));
    checkOutput({tag, "_taken"},   32'(taken),  32'(et));
    checkOutput({tag, "_next_pc"}, next_pc,     epc);
  endtask

  task automatic ackResult(input string tag);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    checkOutput({tag, "_ack_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_ack_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ack = 1'b0; op = OP_NONE; A = '0; pc_in = '0; imm = '0;
    #2;
    checkOutput("rst_busy",    32'(busy),   32'd0);
    checkOutput("rst_done",    32'(done),   32'd0);
    checkOutput("rst_a_zero",  32'(a_zero), 32'd0);
    checkOutput("rst_taken",   32'(taken),  32'd0);
    checkOutput("rst_next_pc", next_pc,     32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_no_start_busy", 32'(busy), 32'd0);

    runBranch("beqz_zero", OP_BEQZ, 32'h0000_0000, 32'h100, 32'h10, 1'b1, 1'b1, 32'h111);
    ackResult("beqz_zero");
    runBranch("bnez_zero", OP_BNEZ, 32'h0000_0000, 32'h100, 32'h10, 1'b1, 1'b0, 32'h101);
    ackResult("bnez_zero");
    runBranch("bnez_msb", OP_BNEZ, 32'h8000_0000, 32'h100, 32'h10, 1'b0, 1'b1, 32'h111);
    ackResult("bnez_msb");
    runBranch("jump_back", OP_JUMP, 32'h0000_0005, 32'h4, 32'hFFFF_FFFB, 1'b0, 1'b1, 32'h0);
    ackResult("jump_back");
    runBranch("jump_wrap", OP_JUMP, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 32'h0);
    ackResult("jump_wrap");
    runBranch("beqz_nt", OP_BEQZ, 32'h0000_0001, 32'h20, 32'h40, 1'b0, 1'b0, 32'h21);
    ackResult("beqz_nt");

    // DONE must hold while ack stays low, even with fresh start requests arriving.
    runBranch("hold", OP_BNEZ, 32'h0000_0003, 32'h300, 32'h7, 1'b0, 1'b1, 32'h308);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; op = OP_BEQZ; A = '0; pc_in = 32'(i * 16); imm = 32'h55;
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d_done", i),    32'(done),   32'd1);
      checkOutput($sformatf("hold%0d_taken", i),   32'(taken),  32'd1);
      checkOutput($sformatf("hold%0d_a_zero", i),  32'(a_zero), 32'd0);
      checkOutput($sformatf("hold%0d_next_pc", i), next_pc,     32'h308);
    end
    start = 1'b0;
    ackResult("hold");

    // ack in IDLE is ignored and results are retained.
    ack = 1'b1;
    repeat (2) @(posedge clk);
    #1; ack = 1'b0;
    checkOutput("idle_ack_busy",    32'(busy),  32'd0);
    checkOutput("idle_ack_done",    32'(done),  32'd0);
    checkOutput("idle_keep_taken",  32'(taken), 32'd1);
    checkOutput("idle_keep_nextpc", next_pc,    32'h308);

    // Asynchronous reset while the request sits in ADDR.
    applyStimulus(OP_JUMP, 32'h0, 32'h40, 32'h10);
    @(posedge clk); #1;
    checkOutput("pre_rst_a_zero", 32'(a_zero), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_busy",    32'(busy),   32'd0);
    checkOutput("async_done",    32'(done),   32'd0);
    checkOutput("async_taken",   32'(taken),  32'd0);
    checkOutput("async_a_zero",  32'(a_zero), 32'd0);
    checkOutput("async_next_pc", next_pc,     32'd0);
    @(negedge clk); rst_n = 1'b1;
    runBranch("post_rst_none", OP_NONE, 32'h0, 32'h200, 32'h5, 1'b1, 1'b0, 32'h201);
    ackResult("post_rst_none");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
